// File: rtl/fpu_ss_mem_buffer.sv
// fpu_ss_mem_buffer
// Circular buffer tracking in-flight FP memory requests. It records the
// offload id, destination register and write-enable of each request, then
// presents them in order when the memory result arrives. A sticky flag
// records any result whose id does not match the head entry.
//
// Optional feature: define FPU_SS_MEM_BUF_FALLTHROUGH_EN to let a request
// pass straight from push_* to pop_* when the buffer is empty. In the
// default build there is no combinational path from push_* to pop_*.
module fpu_ss_mem_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_valid_i,
  output logic                       push_ready_o,
  input  logic [3:0]                 push_id_i,
  input  logic [4:0]                 push_rd_i,
  input  logic                       push_we_i,
  input  logic                       pop_ready_i,
  output logic                       pop_valid_o,
  output logic [3:0]                 pop_id_o,
  output logic [4:0]                 pop_rd_o,
  output logic                       pop_we_o,
  input  logic [3:0]                 result_id_i,
  output logic                       id_mismatch_o,
  output logic [$clog2(DEPTH):0]     usage_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int USE_W = PTR_W + 1;
  localparam logic [USE_W-1:0] FULL_COUNT = USE_W'(DEPTH);

  // Payload storage
  logic [3:0] id_mem [DEPTH];
  logic [4:0] rd_mem [DEPTH];
  logic       we_mem [DEPTH];

  // Control state
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [USE_W-1:0] usage_q,  usage_d;
  logic             mismatch_q, mismatch_d;

  // Handshake decode
  logic empty;
  logic full;
  logic push_fire;   // push handshake completed
  logic pop_fire;    // pop handshake completed (buffered or bypassed)
  logic store;       // push that actually writes an entry
  logic buf_pop;     // pop that actually consumes a stored entry

  assign empty        = (usage_q == '0);
  assign full         = (usage_q == FULL_COUNT);
  assign push_ready_o = ~full & ~flush_i;
  assign push_fire    = push_valid_i & push_ready_o;
  assign pop_fire     = pop_valid_o & pop_ready_i;

`ifdef FPU_SS_MEM_BUF_FALLTHROUGH_EN
  // Head selection: an empty buffer forwards the incoming request directly.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // through the block leaves a value unassigned and infers a latch.
    pop_valid_o = 1'b1;
    pop_id_o    = id_mem[rd_ptr_q];
    pop_rd_o    = rd_mem[rd_ptr_q];
    pop_we_o    = we_mem[rd_ptr_q];
    if (empty) begin
      pop_valid_o = push_valid_i;
      pop_id_o    = push_id_i;
      pop_rd_o    = push_rd_i;
      pop_we_o    = push_we_i;
    end
  end

  // A request consumed in the same cycle it arrives into an empty buffer
  // is never written; only stored entries move the read pointer.
  assign store   = push_fire & ~(empty & pop_fire);
  assign buf_pop = pop_fire & ~empty;
`else
  // Head selection: outputs come only from storage (one-cycle latency).
  always_comb begin
    pop_valid_o = ~empty;
    pop_id_o    = id_mem[rd_ptr_q];
    pop_rd_o    = rd_mem[rd_ptr_q];
    pop_we_o    = we_mem[rd_ptr_q];
  end

  assign store   = push_fire;
  assign buf_pop = pop_fire;
`endif

  // Next-state computation for pointers, occupancy and the mismatch flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    usage_d    = usage_q;
    mismatch_d = mismatch_q;

    if (flush_i) begin
      // Flush wins over any simultaneous pop; payload is left untouched.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      usage_d    = '0;
      mismatch_d = 1'b0;
    end else begin
      if (store) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (buf_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({store, buf_pop})
        2'b10:   usage_d = usage_q + USE_W'(1);
        2'b01:   usage_d = usage_q - USE_W'(1);
        default: usage_d = usage_q;
      endcase
      if (pop_fire && (result_id_i != pop_id_o)) begin
        mismatch_d = 1'b1;
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples its pre-edge value regardless of statement order.
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      usage_q    <= '0;
      mismatch_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      usage_q    <= usage_d;
      mismatch_q <= mismatch_d;
    end
  end

  // Payload write port; storage is cleared on reset so an empty buffer
  // presents all-zero head fields.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: the memory is reset here on purpose (small flop array, zeroed
    // head fields are observable); large RAMs would normally not be reset.
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        id_mem[i] <= '0;
        rd_mem[i] <= '0;
        we_mem[i] <= 1'b0;
      end
    end else if (store) begin
      id_mem[wr_ptr_q] <= push_id_i;
      rd_mem[wr_ptr_q] <= push_rd_i;
      we_mem[wr_ptr_q] <= push_we_i;
    end
  end

  assign usage_o       = usage_q;
  assign id_mismatch_o = mismatch_q;

endmodule

// File: doc/fpu_ss_mem_buffer.md
FPU_SS_MEM_BUFFER -- requirements
Module: fpu_ss_mem_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of in-flight memory request entries (power of two, >=2).
REQ-002 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flush_i  input  1  synchronous clear of all entries and the error flag.
REQ-005 SHALL have port push_valid_i  input  1  memory request handshake completed; metadata valid.
REQ-006 SHALL have port push_ready_o  output  1  buffer can accept an entry.
REQ-007 SHALL have port push_id_i  input  4  offload instruction id.
REQ-008 SHALL have port push_rd_i  input  5  FP destination register.
REQ-009 SHALL have port push_we_i  input  1  entry writes the FP register file (load).
REQ-010 SHALL have port pop_ready_i  input  1  memory result consumed (driven by x_mem_result_valid).
REQ-011 SHALL have port pop_valid_o  output  1  head entry valid.
REQ-012 SHALL have ports pop_id_o  output  4, pop_rd_o  output  5, pop_we_o  output  1  head entry fields.
REQ-013 SHALL have port result_id_i  input  4  id returned with the memory result.
REQ-014 SHALL have port id_mismatch_o  output  1  sticky: a pop occurred with result_id_i != pop_id_o.
REQ-015 SHALL have port usage_o  output  $clog2(DEPTH)+1  number of stored entries.

Function
REQ-016 SHALL store entries in a circular buffer with write and read pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-017 SHALL drive push_ready_o = (usage_o != DEPTH) & ~flush_i; push accepted on push_valid_i & push_ready_o.
REQ-018 SHALL drive pop_valid_o = (usage_o != 0) and pop_*_o from the entry at the read pointer; pop on pop_valid_o & pop_ready_i.
REQ-019 SHALL ignore pop_ready_i when pop_valid_o is low: no pointer, usage or flag change (no underflow).
REQ-020 SHALL, on simultaneous push and pop, advance both pointers and leave usage_o unchanged.
REQ-021 SHALL, when full, hold push_ready_o low even if a pop occurs in the same cycle; the pop alone is performed.
REQ-022 SHALL make a pushed entry visible on pop outputs one cycle after the push (latency 1).
REQ-023 SHALL set id_mismatch_o in the cycle after a pop with result_id_i != pop_id_o and hold it until flush or reset.
REQ-024 SHALL, with flush_i high, zero pointers, usage_o and id_mismatch_o next cycle; a pop in the same cycle has no effect beyond the flush.
REQ-025 SHALL not alter stored payload on flush; it becomes unreachable.

Reset
REQ-026 SHALL on rst_ni low asynchronously clear pointers, usage_o=0, id_mismatch_o=0, giving push_ready_o=1, pop_valid_o=0.
REQ-027 SHALL drive pop_id_o, pop_rd_o, pop_we_o to 0 while empty after reset (payload storage reset to 0).
REQ-028 SHALL discard all entries when reset is asserted mid-operation; no entry survives.

Configuration
REQ-029 SHALL, with macro FPU_SS_MEM_BUF_FALLTHROUGH_EN defined, when empty, drive pop_valid_o = push_valid_i and pop_*_o = push_*_i combinationally; if popped that cycle the entry is not stored and usage_o stays 0.
REQ-030 SHALL, without FPU_SS_MEM_BUF_FALLTHROUGH_EN, show no combinational path from push_* to pop_* (REQ-022 latency).

Verification
REQ-031 Bench SHALL push ids 1,2,3,4 (DEPTH=4) -> push_ready_o=0, usage_o=4; pop four with matching result_id_i -> ids 1,2,3,4 in order, id_mismatch_o=0.
REQ-032 Bench SHALL fill 3, then push id 5 and pop in the same cycle -> usage_o stays 3; repeat 6 times -> pointers wrap, order preserved.
REQ-033 Bench SHALL pop id 2 with result_id_i=7 -> id_mismatch_o=1 next cycle, stays 1 until flush_i pulse, then 0.
REQ-034 Bench SHALL pulse pop_ready_i while empty -> usage_o=0, id_mismatch_o=0, no state change.
REQ-035 Bench SHALL assert rst_ni low with 2 entries stored -> usage_o=0, pop_valid_o=0, push_ready_o=1 immediately.
REQ-036 Bench SHALL, with FPU_SS_MEM_BUF_FALLTHROUGH_EN, push rd=9 into empty buffer with pop_ready_i=1 -> pop_rd_o=9 same cycle, usage_o=0 next cycle; without macro -> pop_valid_o=0 that cycle, 1 next.
